// File: rtl/iserdes_sdr.sv
// iserdes_sdr: serial-to-parallel deserializer, bitslip alignment built only under ISERDES_BITSLIP_EN.
// Latency: word on Q (with Q_VALID) the cycle after the edge that samples its last bit.
// Backpressure: none; CE low freezes all state and suppresses Q_VALID.
module iserdes_sdr #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_Q     = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  D,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VALID
);

  localparam int              CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_width_check
    $error("iserdes_sdr: DATA_WIDTH must be in 2..8");
  end

  logic [DATA_WIDTH-2:0] sr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] word;
  logic                  slip_accept;
  logic                  emit;

  assign word = {sr, D};

`ifdef ISERDES_BITSLIP_EN
  logic [1:0] lock;

  // A slip request is only honoured once the previous slip has settled.
  assign slip_accept = BITSLIP && (lock == 2'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock <= 2'd0;
    end else if (CE) begin
      if (slip_accept) begin
        lock <= 2'd2;
      end else if (lock != 2'd0) begin
        lock <= lock - 2'd1;
      end
    end
  end
`else
  logic unused_bitslip;

  assign slip_accept    = 1'b0;
  assign unused_bitslip = BITSLIP;
`endif

  // A slip on the boundary bit stretches the current word by one bit instead of emitting it.
  assign emit = CE && (cnt == LAST) && !slip_accept;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr      <= '0;
      cnt     <= '0;
      Q       <= INIT_Q;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= emit;
      if (CE) begin
        sr <= word[DATA_WIDTH-2:0];
        if (slip_accept) begin
          cnt <= cnt;
        end else if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (emit) begin
        Q <= word;
      end
    end
  end

endmodule
